riscv_alu_arbiter: RTL and testbench

RISCV_ALU_ARBITER -- requirements
Module: riscv_alu_arbiter

---
 rtl/riscv_alu_arbiter_pkg.sv | 39 +++
 rtl/riscv_alu_arbiter_alu.sv | 33 +++
 rtl/riscv_alu_arbiter.sv | 138 +++++++++++++
 tb/tb_riscv_alu_arbiter.sv | 304 ++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/riscv_alu_arbiter_pkg.sv
// Shared types and constants for the two-requester ALU arbiter and its ALU.
// Opcode encodings and bus widths replace the old riscv_define.v macros.
package riscv_alu_arbiter_pkg;

    localparam int unsigned REG_BUS_W = 32;
    localparam int unsigned ALU_OP_W  = 4;

    typedef enum logic [ALU_OP_W-1:0] {
        ALU_ADD  = 4'd0,
        ALU_SUB  = 4'd1,
        ALU_SLL  = 4'd2,
        ALU_SRL  = 4'd3,
        ALU_SRA  = 4'd4,
        ALU_AND  = 4'd5,
        ALU_OR   = 4'd6,
        ALU_XOR  = 4'd7,
        ALU_SLT  = 4'd8,
        ALU_SLTU = 4'd9
    } alu_op_e;

    localparam logic ARB_REQ0 = 1'b0;
    localparam logic ARB_REQ1 = 1'b1;

    typedef enum logic {
        SLOT_EMPTY = 1'b0,
        SLOT_FULL  = 1'b1
    } slot_state_e;

    // Round-robin pick: on contention the requester other than last_grant wins.
    function automatic logic [1:0] rr_pick(input logic [1:0] elig, input logic last_grant);
        logic [1:0] grant;
        grant = elig;
        if (elig == 2'b11) begin
            grant = (last_grant == ARB_REQ1) ? 2'b01 : 2'b10;
        end
        return grant;
    endfunction

endpackage

// File: rtl/riscv_alu_arbiter_alu.sv
// Purely combinational RV32 integer ALU shared by the arbiter's requesters.
module riscv_alu
    import riscv_alu_arbiter_pkg::*;
(
    input  logic [ALU_OP_W-1:0]  op_i,
    input  logic [REG_BUS_W-1:0] a_i,
    input  logic [REG_BUS_W-1:0] b_i,
    output logic [REG_BUS_W-1:0] result_o,
    output logic                 zero_o
);

    logic [4:0] shamt;

    always_comb begin
        shamt    = b_i[4:0];
        result_o = '0;
        case (alu_op_e'(op_i))
            ALU_ADD:  result_o = a_i + b_i;
            ALU_SUB:  result_o = a_i - b_i;
            ALU_SLL:  result_o = a_i << shamt;
            ALU_SRL:  result_o = a_i >> shamt;
            ALU_SRA:  result_o = $unsigned($signed(a_i) >>> shamt);
            ALU_AND:  result_o = a_i & b_i;
            ALU_OR:   result_o = a_i | b_i;
            ALU_XOR:  result_o = a_i ^ b_i;
            ALU_SLT:  result_o = {{(REG_BUS_W-1){1'b0}}, ($signed(a_i) < $signed(b_i))};
            ALU_SLTU: result_o = {{(REG_BUS_W-1){1'b0}}, (a_i < b_i)};
            default:  result_o = '0;
        endcase
        zero_o = (result_o == '0);
    end

endmodule

// File: rtl/riscv_alu_arbiter.sv
// Two-requester round-robin front end for one shared ALU, with a one-deep
// registered response slot per requester (drain and refill in the same cycle).
module riscv_alu_arbiter
    import riscv_alu_arbiter_pkg::*;
(
    input  logic                 clk_i,
    input  logic                 rst_i,

    input  logic                 req0_valid_i,
    output logic                 req0_ready_o,
    input  logic [ALU_OP_W-1:0]  req0_op_i,
    input  logic [REG_BUS_W-1:0] req0_a_i,
    input  logic [REG_BUS_W-1:0] req0_b_i,
    output logic                 resp0_valid_o,
    input  logic                 resp0_ready_i,
    output logic [REG_BUS_W-1:0] resp0_result_o,
    output logic                 resp0_zero_o,

    input  logic                 req1_valid_i,
    output logic                 req1_ready_o,
    input  logic [ALU_OP_W-1:0]  req1_op_i,
    input  logic [REG_BUS_W-1:0] req1_a_i,
    input  logic [REG_BUS_W-1:0] req1_b_i,
    output logic                 resp1_valid_o,
    input  logic                 resp1_ready_i,
    output logic [REG_BUS_W-1:0] resp1_result_o,
    output logic                 resp1_zero_o
);

    slot_state_e          slot_q   [2];
    slot_state_e          slot_d   [2];
    logic [REG_BUS_W-1:0] result_q [2];
    logic [REG_BUS_W-1:0] result_d [2];
    logic                 zero_q   [2];
    logic                 zero_d   [2];
    logic                 last_grant_q;
    logic                 last_grant_d;

    logic [1:0]           req_valid;
    logic [1:0]           resp_ready;
    logic [1:0]           elig;
    logic [1:0]           grant;

    logic [ALU_OP_W-1:0]  alu_op;
    logic [REG_BUS_W-1:0] alu_a;
    logic [REG_BUS_W-1:0] alu_b;
    logic [REG_BUS_W-1:0] alu_result;
    logic                 alu_zero;

    assign req_valid  = {req1_valid_i, req0_valid_i};
    assign resp_ready = {resp1_ready_i, resp0_ready_i};

    // Eligibility and grant; no grant is ever issued while reset is asserted.
    always_comb begin
        elig  = '0;
        grant = '0;
        for (int unsigned i = 0; i < 2; i++) begin
            elig[i] = req_valid[i] && ((slot_q[i] == SLOT_EMPTY) || resp_ready[i]);
        end
        if (!rst_i) begin
            grant = rr_pick(elig, last_grant_q);
        end
    end

    assign req0_ready_o = grant[0];
    assign req1_ready_o = grant[1];

    // Operand mux defaults to requester 0 when idle.
    always_comb begin
        alu_op = req0_op_i;
        alu_a  = req0_a_i;
        alu_b  = req0_b_i;
        if (grant[1]) begin
            alu_op = req1_op_i;
            alu_a  = req1_a_i;
            alu_b  = req1_b_i;
        end
    end

    riscv_alu u_alu (
        .op_i     (alu_op),
        .a_i      (alu_a),
        .b_i      (alu_b),
        .result_o (alu_result),
        .zero_o   (alu_zero)
    );

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            last_grant_q <= ARB_REQ1;
            for (int unsigned i = 0; i < 2; i++) begin
                slot_q[i]   <= SLOT_EMPTY;
                result_q[i] <= '0;
                zero_q[i]   <= 1'b0;
            end
        end else begin
            last_grant_q <= last_grant_d;
            for (int unsigned i = 0; i < 2; i++) begin
                slot_q[i]   <= slot_d[i];
                result_q[i] <= result_d[i];
                zero_q[i]   <= zero_d[i];
            end
        end
    end

    // A grant always (re)fills its slot; a drain without refill empties it but
    // leaves the stale data in place since it is invisible once EMPTY.
    always_comb begin
        last_grant_d = last_grant_q;
        if (grant[1]) begin
            last_grant_d = ARB_REQ1;
        end else if (grant[0]) begin
            last_grant_d = ARB_REQ0;
        end
        for (int unsigned i = 0; i < 2; i++) begin
            slot_d[i]   = slot_q[i];
            result_d[i] = result_q[i];
            zero_d[i]   = zero_q[i];
            if (grant[i]) begin
                slot_d[i]   = SLOT_FULL;
                result_d[i] = alu_result;
                zero_d[i]   = alu_zero;
            end else if ((slot_q[i] == SLOT_FULL) && resp_ready[i]) begin
                slot_d[i] = SLOT_EMPTY;
            end
        end
    end

    always_comb begin
        resp0_valid_o  = (slot_q[0] == SLOT_FULL);
        resp1_valid_o  = (slot_q[1] == SLOT_FULL);
        resp0_result_o = result_q[0];
        resp1_result_o = result_q[1];
        resp0_zero_o   = zero_q[0];
        resp1_zero_o   = zero_q[1];
    end

endmodule

// File: tb/tb_riscv_alu_arbiter.sv
// Bench for riscv_alu_arbiter: directed scenarios with literal expectations plus
// randomized traffic compared every cycle against a behavioural slot/round-robin model.
module tb_riscv_alu_arbiter;
    import riscv_alu_arbiter_pkg::*;

    logic        clk = 1'b0;
    logic        rst;
    logic        v0, v1, rdy0, rdy1, rv0, rv1, rr0, rr1, z0, z1;
    logic [3:0]  op0, op1;
    logic [31:0] a0, b0, a1, b1, res0, res1;

    int checks = 0;
    int passed = 0;

    always #5 clk = ~clk;

    riscv_alu_arbiter dut (
        .clk_i          (clk),
        .rst_i          (rst),
        .req0_valid_i   (v0),
        .req0_ready_o   (rdy0),
        .req0_op_i      (op0),
        .req0_a_i       (a0),
        .req0_b_i       (b0),
        .resp0_valid_o  (rv0),
        .resp0_ready_i  (rr0),
        .resp0_result_o (res0),
        .resp0_zero_o   (z0),
        .req1_valid_i   (v1),
        .req1_ready_o   (rdy1),
        .req1_op_i      (op1),
        .req1_a_i       (a1),
        .req1_b_i       (b1),
        .resp1_valid_o  (rv1),
        .resp1_ready_i  (rr1),
        .resp1_result_o (res1),
        .resp1_zero_o   (z1)
    );

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act === exp) passed++;
        else $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    endtask

    function automatic logic [31:0] alu_ref(input logic [3:0] op, input logic [31:0] a, input logic [31:0] b);
        int unsigned sh;
        sh = b % 32;
        case (op)
            4'd0: return a + b;
            4'd1: return a + (~b + 32'd1);
            4'd2: return a * (32'd1 << sh);
            4'd3: return a / (32'd1 << sh);
            4'd4: return (a >> sh) | ((a[31] && sh != 0) ? ~(32'hFFFF_FFFF >> sh) : 32'd0);
            4'd5: return a & b;
            4'd6: return a | b;
            4'd7: return a ^ b;
            4'd8: return ((a ^ 32'h8000_0000) < (b ^ 32'h8000_0000)) ? 32'd1 : 32'd0;
            4'd9: return (a < b) ? 32'd1 : 32'd0;
            default: return 32'd0;
        endcase
    endfunction

    // Behavioural model: slot contents, last grant, starvation counters.
    bit          m_full [2];
    logic [31:0] m_res  [2];
    bit          m_zero [2];
    bit          m_last;
    bit          m_init = 1'b0;
    bit          n_full [2];
    logic [31:0] n_res  [2];
    bit          n_zero [2];
    bit          n_last;
    bit          n_init = 1'b0;
    int          starve [2];
    bit [1:0]    e, g, dut_rdy, vv, rr;
    logic [3:0]  ops [2];
    logic [31:0] as_ [2];
    logic [31:0] bs_ [2];
    logic [31:0] dut_res [2];
    bit   [1:0]  dut_val, dut_zero;

    always @(negedge clk) begin
        vv = {v1, v0};
        rr = {rr1, rr0};
        ops[0] = op0; ops[1] = op1;
        as_[0] = a0;  as_[1] = a1;
        bs_[0] = b0;  bs_[1] = b1;
        dut_rdy = {rdy1, rdy0};
        dut_val = {rv1, rv0};
        dut_zero = {z1, z0};
        dut_res[0] = res0; dut_res[1] = res1;
        e = '0;
        g = '0;
        for (int n = 0; n < 2; n++) e[n] = vv[n] && (!m_full[n] || rr[n]);
        if (!rst) begin
            if (e[0] && e[1]) g[m_last ? 0 : 1] = 1'b1;
            else g = e;
        end
        chk("ready0", rdy0, g[0]);
        chk("ready1", rdy1, g[1]);
        if (m_init) begin
            for (int n = 0; n < 2; n++) begin
                chk($sformatf("resp%0d_valid", n), dut_val[n], m_full[n]);
                if (m_full[n]) begin
                    chk($sformatf("resp%0d_result", n), dut_res[n], m_res[n]);
                    chk($sformatf("resp%0d_zero", n), dut_zero[n], m_zero[n]);
                end
            end
        end
        for (int n = 0; n < 2; n++) begin
            if (!rst && e[n] && !dut_rdy[n]) starve[n]++;
            else starve[n] = 0;
            if (!rst && e[n]) chk($sformatf("starve%0d", n), starve[n] < 2, 1'b1);
        end
        n_last = m_last;
        for (int n = 0; n < 2; n++) begin
            n_full[n] = m_full[n];
            n_res[n]  = m_res[n];
            n_zero[n] = m_zero[n];
        end
        n_init = m_init;
        if (rst) begin
            n_init = 1'b1;
            n_last = 1'b1;
            for (int n = 0; n < 2; n++) begin
                n_full[n] = 1'b0;
                n_res[n]  = 32'd0;
                n_zero[n] = 1'b0;
            end
        end else begin
            for (int n = 0; n < 2; n++) begin
                if (g[n]) begin
                    n_full[n] = 1'b1;
                    n_res[n]  = alu_ref(ops[n], as_[n], bs_[n]);
                    n_zero[n] = (n_res[n] == 32'd0);
                    n_last    = (n == 1);
                end else if (m_full[n] && rr[n]) begin
                    n_full[n] = 1'b0;
                end
            end
        end
    end

    always @(posedge clk) begin
        m_init = n_init;
        m_last = n_last;
        for (int n = 0; n < 2; n++) begin
            m_full[n] = n_full[n];
            m_res[n]  = n_res[n];
            m_zero[n] = n_zero[n];
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic idle();
        v0 = 1'b0; v1 = 1'b0; rr0 = 1'b1; rr1 = 1'b1;
    endtask

    function automatic logic [31:0] rand_operand();
        case ($urandom_range(0, 3))
            0: return $urandom_range(0, 40);
            1: return 32'h8000_0000 | $urandom_range(0, 15);
            2: return 32'hFFFF_FFFF - $urandom_range(0, 3);
            default: return $urandom;
        endcase
    endfunction

    initial begin
        rst = 1'b1;
        idle();
        op0 = ALU_ADD; op1 = ALU_ADD;
        a0 = '0; b0 = '0; a1 = '0; b1 = '0;
        starve[0] = 0; starve[1] = 0;
        tick();
        tick();
        rst = 1'b0;
        @(negedge clk);
        chk("rst_valid0", rv0, 1'b0);
        chk("rst_result0", res0, 32'h0);
        chk("rst_zero1", z1, 1'b0);

        // Single request ADD 5,7
        tick();
        v0 = 1'b1; op0 = ALU_ADD; a0 = 32'd5; b0 = 32'd7;
        @(negedge clk);
        chk("single_ready0", rdy0, 1'b1);
        tick();
        v0 = 1'b0;
        @(negedge clk);
        chk("single_valid0", rv0, 1'b1);
        chk("single_result0", res0, 32'd12);
        chk("single_zero0", z0, 1'b0);

        // Contention right after reset
        tick();
        rst = 1'b1;
        tick();
        rst = 1'b0;
        v0 = 1'b1; op0 = ALU_SUB; a0 = 32'd3; b0 = 32'd3;
        v1 = 1'b1; op1 = ALU_SRA; a1 = 32'h8000_0000; b1 = 32'd4;
        for (int k = 0; k < 4; k++) begin
            @(negedge clk);
            chk("contend_ready0", rdy0, (k % 2) == 0);
            chk("contend_ready1", rdy1, (k % 2) == 1);
            if (k == 1) begin
                chk("contend_res0", res0, 32'h0);
                chk("contend_zero0", z0, 1'b1);
            end
            if (k == 2) begin
                chk("contend_valid1", rv1, 1'b1);
                chk("contend_res1", res1, 32'hF800_0000);
            end
            tick();
        end

        // Backpressure on requester 1
        idle();
        tick();
        v1 = 1'b1; op1 = ALU_SLTU; a1 = 32'd1; b1 = 32'd2; rr1 = 1'b0;
        @(negedge clk);
        chk("bp_ready1_first", rdy1, 1'b1);
        tick();
        op1 = ALU_ADD; a1 = 32'd10; b1 = 32'd20;
        v0 = 1'b1; op0 = ALU_ADD; a0 = 32'd1; b0 = 32'd1;
        @(negedge clk);
        chk("bp_ready1_blocked", rdy1, 1'b0);
        chk("bp_ready0", rdy0, 1'b1);
        chk("bp_hold_res1", res1, 32'd1);
        tick();
        rr1 = 1'b1;
        @(negedge clk);
        chk("bp_refill_ready1", rdy1, 1'b1);
        chk("bp_refill_ready0", rdy0, 1'b0);
        tick();
        v1 = 1'b0;
        @(negedge clk);
        chk("bp_refill_res1", res1, 32'd30);
        chk("bp_refill_valid1", rv1, 1'b1);

        // Streaming SLL 1,k
        tick();
        idle();
        v0 = 1'b1; op0 = ALU_SLL; a0 = 32'd1;
        for (int k = 0; k < 32; k++) begin
            b0 = k;
            @(negedge clk);
            chk("stream_ready0", rdy0, 1'b1);
            if (k > 0) chk("stream_res0", res0, 32'd1 << (k - 1));
            tick();
        end
        v0 = 1'b0;
        @(negedge clk);
        chk("stream_last_res0", res0, 32'h8000_0000);

        // Reset while both slots are full
        tick();
        v0 = 1'b1; v1 = 1'b1; rr0 = 1'b0; rr1 = 1'b0;
        op0 = ALU_OR; a0 = 32'h0F; b0 = 32'hF0;
        op1 = ALU_XOR; a1 = 32'h55; b1 = 32'hAA;
        tick();
        tick();
        @(negedge clk);
        chk("midrst_full0", rv0, 1'b1);
        chk("midrst_full1", rv1, 1'b1);
        tick();
        rst = 1'b1;
        tick();
        rst = 1'b0;
        rr0 = 1'b1; rr1 = 1'b1;
        @(negedge clk);
        chk("midrst_valid0", rv0, 1'b0);
        chk("midrst_valid1", rv1, 1'b0);
        chk("midrst_grant0", rdy0, 1'b1);
        chk("midrst_grant1", rdy1, 1'b0);

        // Randomized traffic
        for (int c = 0; c < 800; c++) begin
            tick();
            rst = ($urandom_range(0, 63) == 0);
            v0  = ($urandom_range(0, 3) != 0);
            v1  = ($urandom_range(0, 3) != 0);
            rr0 = ($urandom_range(0, 2) != 0);
            rr1 = ($urandom_range(0, 2) != 0);
            op0 = $urandom_range(0, 9);
            op1 = $urandom_range(0, 9);
            a0 = rand_operand(); b0 = rand_operand();
            a1 = rand_operand(); b1 = rand_operand();
        end
        tick();
        rst = 1'b0;
        idle();
        tick();
        tick();
        @(negedge clk);
        $display("%0d/%0d checks passed", passed, checks);
        $finish;
    end

endmodule
